ecdsa_sign_finish: RTL and testbench

Downstream consumer of the scalar-multiplication stage in the ECDSA signing path.
- Takes R = k·G's x-coordinate, plus nonce k, message hash e, private key d and group order n.
- Computes the signature pair r = Rx mod n and s = k⁻¹·(e + r·d) mod n.
- Multi-cycle and bit-serial, so one instance costs one WIDTH-bit serial multiplier plus one binary-inverse datapath.

---
 rtl/ecdsa_pkg.sv | 22 ++
 rtl/mod_mul_serial.sv | 68 ++++++
 rtl/ecdsa_sign_finish.sv | 216 +++++++++++++++++++++
 tb/tb_ecdsa_sign_finish.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ecdsa_pkg.sv
// Shared state encoding and sizing helpers for the ECDSA signature finishing stage.
package ecdsa_pkg;

  localparam int WIDTH_DEF = 256;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    MUL_RD,
    ADD,
    INV,
    MUL_S,
    CHECK,
    DONE
  } state_e;

  // Iteration ceiling for the binary inverse loop.
  function automatic int inv_bound(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// MSB-first interleaved modular multiplier p = a*b mod n (a < n); one bit of b per cycle.
// done pulses WIDTH cycles after start; start always (re)loads, so the caller owns sequencing.
module mod_mul_serial
  import ecdsa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] a_q, b_q, n_q, acc_q, acc_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH:0]   dbl, dbl_red, sum;

  always_comb begin
    dbl     = {acc_q, 1'b0};
    dbl_red = (dbl >= {1'b0, n_q}) ? dbl - {1'b0, n_q} : dbl;
    sum     = dbl_red + (b_q[WIDTH-1] ? {1'b0, a_q} : '0);
    acc_d   = WIDTH'((sum >= {1'b0, n_q}) ? sum - {1'b0, n_q} : sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        // First iteration folded into the load: 2*0 + (msb ? a : 0).
        a_q    <= a;
        b_q    <= b << 1;
        n_q    <= n;
        acc_q  <= b[WIDTH-1] ? a : '0;
        cnt_q  <= CW'(WIDTH - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        acc_q <= acc_d;
        b_q   <= b_q << 1;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = acc_q;

endmodule

// File: rtl/ecdsa_sign_finish.sv
// Computes r = Rx mod n and s = k^-1 (e + r d) mod n; worst case 4*WIDTH+4 cycles capture to out_valid.
// Single job in flight: in_ready only in IDLE, result held in DONE until out_ready.
module ecdsa_sign_finish
  import ecdsa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rx,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sig_r,
  output logic [WIDTH-1:0] sig_s,
  output logic             sig_err
);

  localparam int               ICW     = $clog2(inv_bound(WIDTH) + 1);
  localparam logic [ICW-1:0]   INV_MAX = ICW'(inv_bound(WIDTH));
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, e_q, e_d, d_q, d_d, k_q, k_d, n_q, n_d;
  logic [WIDTH-1:0] t_q, t_d, u_q, u_d, s_q, s_d;
  logic [WIDTH-1:0] iu_q, iu_d, iv_q, iv_d, x1_q, x1_d, x2_q, x2_d;
  logic [ICW-1:0]   icnt_q, icnt_d;
  logic             err_q, err_d;

  logic             mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_a, mul_b, mul_p;
  logic [WIDTH-1:0] r_red, e_red;
  logic [WIDTH:0]   u_sum;

  // x/2 mod n for odd n: odd x is lifted by n first so the shift is exact.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return WIDTH'(s >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] m);
    return (a >= b) ? a - b : a - b + m;
  endfunction

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(mul_start),
    .a    (mul_a),
    .b    (mul_b),
    .n    (n_q),
    .busy (mul_busy),
    .done (mul_done),
    .p    (mul_p)
  );

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    e_d       = e_q;
    d_d       = d_q;
    k_d       = k_q;
    n_d       = n_q;
    t_d       = t_q;
    u_d       = u_q;
    s_d       = s_q;
    iu_d      = iu_q;
    iv_d      = iv_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    icnt_d    = icnt_q;
    err_d     = err_q;
    mul_start = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    r_red     = (r_q >= n_q) ? r_q - n_q : r_q;
    e_red     = (e_q >= n_q) ? e_q - n_q : e_q;
    u_sum     = {1'b0, e_q} + {1'b0, t_q};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          r_d     = rx;
          e_d     = e;
          d_d     = d;
          k_d     = k;
          n_d     = n;
          s_d     = '0;
          err_d   = 1'b0;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        r_d    = r_red;
        e_d    = e_red;
        iu_d   = k_q;
        iv_d   = n_q;
        x1_d   = ONE;
        x2_d   = '0;
        icnt_d = '0;
        if (k_q == '0 || k_q >= n_q || r_red == '0) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          mul_start = 1'b1;
          mul_a     = r_red;
          mul_b     = d_q;
          state_d   = MUL_RD;
        end
      end
      MUL_RD: begin
        if (mul_done && !mul_busy) begin
          t_d     = mul_p;
          state_d = ADD;
        end
      end
      ADD: begin
        u_d     = WIDTH'((u_sum >= {1'b0, n_q}) ? u_sum - {1'b0, n_q} : u_sum);
        state_d = INV;
      end
      INV: begin
        // Invariants: x1*k == iu and x2*k == iv (mod n).
        if (iu_q == ONE || iv_q == ONE) begin
          mul_start = 1'b1;
          mul_a     = (iu_q == ONE) ? x1_q : x2_q;
          mul_b     = u_q;
          state_d   = MUL_S;
        end else if (icnt_q == INV_MAX) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          icnt_d = icnt_q + 1'b1;
          if (!iu_q[0]) begin
            iu_d = iu_q >> 1;
            x1_d = half_mod(x1_q, n_q);
          end else if (!iv_q[0]) begin
            iv_d = iv_q >> 1;
            x2_d = half_mod(x2_q, n_q);
          end else if (iu_q >= iv_q) begin
            iu_d = (iu_q - iv_q) >> 1;
            x1_d = half_mod(sub_mod(x1_q, x2_q, n_q), n_q);
          end else begin
            iv_d = (iv_q - iu_q) >> 1;
            x2_d = half_mod(sub_mod(x2_q, x1_q, n_q), n_q);
          end
        end
      end
      MUL_S: begin
        if (mul_done && !mul_busy) begin
          s_d     = mul_p;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (s_q == '0) err_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      e_q     <= '0;
      d_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      t_q     <= '0;
      u_q     <= '0;
      s_q     <= '0;
      iu_q    <= '0;
      iv_q    <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      icnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      e_q     <= e_d;
      d_q     <= d_d;
      k_q     <= k_d;
      n_q     <= n_d;
      t_q     <= t_d;
      u_q     <= u_d;
      s_q     <= s_d;
      iu_q    <= iu_d;
      iv_q    <= iv_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      icnt_q  <= icnt_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sig_err   = out_valid && err_q;
  assign sig_r     = (out_valid && !err_q) ? r_q : '0;
  assign sig_s     = (out_valid && !err_q) ? s_q : '0;

endmodule

// File: tb/tb_ecdsa_sign_finish.sv
// Directed bench for ecdsa_sign_finish at WIDTH=8, n=251, with hand-derived signatures.
module tb_ecdsa_sign_finish;

  localparam int W   = 8;
  localparam int LAT = 4 * W + 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] rx = '0, k = '0, e = '0, d = '0, n = 8'd251;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sig_r, sig_s;
  logic         sig_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ecdsa_sign_finish #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rx       (rx),
    .k        (k),
    .e        (e),
    .d        (d),
    .n        (n),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sig_r    (sig_r),
    .sig_s    (sig_s),
    .sig_err  (sig_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one job, waits (bounded) for the result, then completes the handshake.
  task automatic run_job(input logic [W-1:0] rx_v, k_v, e_v, d_v,
                         output int lat, output logic [W-1:0] gr, gs, output logic gerr);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin tick(); guard++; end
    rx = rx_v; k = k_v; e = e_v; d = d_v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin tick(); lat++; end
    gr = sig_r; gs = sig_s; gerr = sig_err;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (sig_r !== 8'd0) begin n_bad++; $display("FAIL reset_sig_r got=%0d want=0", sig_r); end
    n_cmp++; if (sig_s !== 8'd0) begin n_bad++; $display("FAIL reset_sig_s got=%0d want=0", sig_s); end
    n_cmp++; if (sig_err !== 1'b0) begin n_bad++; $display("FAIL reset_sig_err got=%b want=0", sig_err); end
  endtask

  // Successful signatures: nominal, r reduction (k=1), e reduction, e=n-1, k=2, k=n-1.
  task automatic test_sign_ok();
    logic [W-1:0] t_rx [6] = '{8'd16, 8'd255, 8'd16,  8'd16,  8'd16,  8'd16};
    logic [W-1:0] t_k  [6] = '{8'd7,  8'd1,   8'd7,   8'd7,   8'd2,   8'd250};
    logic [W-1:0] t_e  [6] = '{8'd100, 8'd0,  8'd255, 8'd250, 8'd100, 8'd100};
    logic [W-1:0] t_d  [6] = '{8'd3,  8'd1,   8'd3,   8'd3,   8'd3,   8'd3};
    logic [W-1:0] t_r  [6] = '{8'd16, 8'd4,   8'd16,  8'd16,  8'd16,  8'd16};
    logic [W-1:0] t_s  [6] = '{8'd57, 8'd4,   8'd115, 8'd186, 8'd74,  8'd103};
    int lat;
    logic [W-1:0] gr, gs;
    logic gerr;
    for (int i = 0; i < 6; i++) begin
      run_job(t_rx[i], t_k[i], t_e[i], t_d[i], lat, gr, gs, gerr);
      n_cmp++; if (gr !== t_r[i]) begin n_bad++; $display("FAIL sign%0d_r got=%0d want=%0d", i, gr, t_r[i]); end
      n_cmp++; if (gs !== t_s[i]) begin n_bad++; $display("FAIL sign%0d_s got=%0d want=%0d", i, gs, t_s[i]); end
      n_cmp++; if (gerr !== 1'b0) begin n_bad++; $display("FAIL sign%0d_err got=%b want=0", i, gerr); end
      n_cmp++; if (lat > LAT) begin n_bad++; $display("FAIL sign%0d_latency got=%0d want<=%0d", i, lat, LAT); end
    end
  endtask

  // Rejections: r=0, s=0, k=0, k=n. Only s=0 goes through the full datapath.
  task automatic test_errors();
    logic [W-1:0] t_rx [4] = '{8'd251, 8'd16,  8'd16,  8'd16};
    logic [W-1:0] t_k  [4] = '{8'd7,   8'd7,   8'd0,   8'd251};
    logic [W-1:0] t_e  [4] = '{8'd100, 8'd203, 8'd100, 8'd100};
    logic         early[4] = '{1'b1,   1'b0,   1'b1,   1'b1};
    int lat;
    logic [W-1:0] gr, gs;
    logic gerr;
    for (int i = 0; i < 4; i++) begin
      run_job(t_rx[i], t_k[i], t_e[i], 8'd3, lat, gr, gs, gerr);
      n_cmp++; if (gerr !== 1'b1) begin n_bad++; $display("FAIL err%0d_flag got=%b want=1", i, gerr); end
      n_cmp++; if (gr !== 8'd0 || gs !== 8'd0) begin n_bad++; $display("FAIL err%0d_rs got=%0d/%0d want=0/0", i, gr, gs); end
      if (early[i]) begin
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL err%0d_latency got=%0d want=2", i, lat); end
      end else begin
        n_cmp++; if (lat <= 2 || lat > LAT) begin n_bad++; $display("FAIL err%0d_latency got=%0d want 3..%0d", i, lat, LAT); end
      end
    end
  endtask

  // Busy-time in_valid pulses are dropped; a 20-cycle out_ready stall holds the result.
  task automatic test_stall_and_busy();
    int guard;
    bool_t_dummy: begin end
    rx = 8'd16; k = 8'd7; e = 8'd100; d = 8'd3;
    in_valid = 1'b1;
    tick();
    rx = 8'd255; k = 8'd1; e = 8'd0; d = 8'd1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL busy_in_ready cyc%0d got=%b want=0", i, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 200) begin tick(); guard++; end
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || sig_r !== 8'd16 || sig_s !== 8'd57 || sig_err !== 1'b0) begin
        n_bad++;
        $display("FAIL stall cyc%0d got v=%b r=%0d s=%0d err=%b want v=1 r=16 s=57 err=0",
                 i, out_valid, sig_r, sig_s, sig_err);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL handshake_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL handshake_out_valid got=%b want=0", out_valid); end
    guard = 0;
    for (int i = 0; i < 45; i++) begin
      if (out_valid) guard++;
      tick();
    end
    n_cmp++; if (guard !== 0) begin n_bad++; $display("FAIL busy_capture_leak got=%0d valid cycles want=0", guard); end
  endtask

  // Reset while the inverse loop runs, then a clean job must produce only its own result.
  task automatic test_reset_mid();
    int lat, seen;
    logic [W-1:0] gr, gs;
    logic gerr;
    rx = 8'd16; k = 8'd7; e = 8'd100; d = 8'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL midreset_state got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      if (out_valid) seen++;
      tick();
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midreset_stale got=%0d valid cycles want=0", seen); end
    run_job(8'd16, 8'd7, 8'd100, 8'd3, lat, gr, gs, gerr);
    n_cmp++; if (gr !== 8'd16 || gs !== 8'd57 || gerr !== 1'b0) begin
      n_bad++; $display("FAIL midreset_job got r=%0d s=%0d err=%b want r=16 s=57 err=0", gr, gs, gerr);
    end
  endtask

  initial begin
    test_reset();
    test_sign_ok();
    test_errors();
    test_stall_and_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
